// File: rtl/bist_pattern_ctrl.sv
// BIST controller: drives LFSR stimulus into a subcircuit, compacts its one-bit
// response into a MISR signature and compares it against a golden value.
module bist_pattern_ctrl #(
   parameter int unsigned PAT_W      = 3,
   parameter int unsigned N_PATTERNS = 1000,
   parameter int unsigned LAT        = 4,
   parameter logic [15:0] SEED       = 16'h0001
) (
   input  logic             I1470_clk,
   input  logic             I1477_rst,
   input  logic             start,
   input  logic [15:0]      golden_sig,
   input  logic             resp_in,
   output logic [PAT_W-1:0] pat_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      sig_out,
   output logic [15:0]      pat_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [15:0] L_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [16:0] L_N    = 17'(N_PATTERNS);
   localparam logic [16:0] L_LAT  = 17'(LAT);
   localparam logic [16:0] L_LAST = 17'(N_PATTERNS + LAT - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_lfsr;
   logic [15:0] r_misr;
   logic [15:0] r_pat_count;
   logic [15:0] r_cap_cnt;
   logic [16:0] r_cyc;
   logic        r_pass;
   logic        w_cap_en;
   logic        w_start_run;
   logic [15:0] w_lfsr_next;
   logic [15:0] w_misr_next;
   logic [15:0] w_misr_upd;

   assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_misr_next = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]}
                        ^ {15'b0, resp_in};
   assign w_misr_upd  = w_cap_en ? w_misr_next : r_misr;

   always_ff @(posedge I1470_clk or negedge I1477_rst) begin
      if (!I1477_rst) r_state <= S_IDLE;
      else            r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if ({1'b0, r_pat_count} == L_N - 17'd1) w_state_next = S_FLUSH;
         S_FLUSH: if (r_cyc == L_LAST) w_state_next = S_DONE;
         S_DONE:  if (start) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
   end

   // r_cyc indexes RUN+FLUSH as one timeline, so the capture window [LAT, LAT+N)
   // is correct even when N_PATTERNS < LAT and capture begins inside FLUSH.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      pat_out  = '0;
      w_cap_en = 1'b0;
      case (r_state)
         S_RUN: begin
            busy     = 1'b1;
            pat_out  = r_lfsr[PAT_W-1:0];
            w_cap_en = (r_cyc >= L_LAT);
         end
         S_FLUSH: begin
            busy     = 1'b1;
            w_cap_en = (r_cyc >= L_LAT);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
      w_cap_en = w_cap_en && ({1'b0, r_cap_cnt} < L_N);
   end

   always_ff @(posedge I1470_clk or negedge I1477_rst) begin
      if (!I1477_rst) begin
         r_lfsr      <= L_SEED;
         r_misr      <= 16'h0000;
         r_pat_count <= 16'h0000;
         r_cap_cnt   <= 16'h0000;
         r_cyc       <= 17'd0;
         r_pass      <= 1'b0;
      end else if (w_start_run) begin
         r_lfsr      <= L_SEED;
         r_misr      <= 16'h0000;
         r_pat_count <= 16'h0000;
         r_cap_cnt   <= 16'h0000;
         r_cyc       <= 17'd0;
         r_pass      <= 1'b0;
      end else begin
         if (r_state == S_RUN) begin
            r_lfsr      <= w_lfsr_next;
            r_pat_count <= r_pat_count + 16'd1;
         end
         if ((r_state == S_RUN) || (r_state == S_FLUSH)) r_cyc <= r_cyc + 17'd1;
         if (w_cap_en) begin
            r_misr    <= w_misr_next;
            r_cap_cnt <= r_cap_cnt + 16'd1;
         end
         // The final capture lands on the same edge that enters DONE.
         if ((r_state == S_FLUSH) && (w_state_next == S_DONE))
            r_pass <= (w_misr_upd == golden_sig);
      end
   end

   assign pass      = r_pass;
   assign sig_out   = r_misr;
   assign pat_count = r_pat_count;
   assign dbg_state = r_state;

endmodule

// File: doc/bist_pattern_ctrl.md
Name: bist_pattern_ctrl

Overview:
Built-in self-test controller for the netlist subcircuits in the trojan-detection benchmark set. It sits at the other end of the subcircuit interface from the subcircuit itself. It generates pseudo-random stimulus on the subcircuit's data inputs and reads the subcircuit's single output back. The response stream is compacted into a MISR signature, which is compared against a golden signature to flag pass or fail, for example when a trojan is present.

Parameters:
PAT_W, 3, width of pat_out; number of subcircuit data inputs driven (≤16)
N_PATTERNS, 1000, patterns applied per run (1..65535)
LAT, 4, subcircuit input-to-output register latency in cycles (1..15)
SEED, 16'h0001, LFSR load value; 0 is replaced by 16'h0001

Ports:
I1470_clk  input  1  system clock, all flops rising-edge
I1477_rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a run
golden_sig  input  16  expected signature, sampled when entering DONE
resp_in  input  1  subcircuit output being read back
pat_out  output  PAT_W  stimulus to the subcircuit data inputs
busy  output  1  high in RUN and FLUSH
done  output  1  high in DONE
pass  output  1  valid while done; 1 = signature matched
sig_out  output  16  current MISR contents
pat_count  output  16  patterns applied in the current or last run

Behaviour:
- Reset (I1477_rst=0, asynchronous):
  - state=IDLE, lfsr=SEED (or 16'h0001 if SEED=0), misr=0, pat_count=0, cap_cnt=0.
  - Outputs: pat_out=0, busy=0, done=0, pass=0, sig_out=0.
- LFSR (Fibonacci):
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - pat_out = l[PAT_W-1:0] while in RUN; 0 in all other states.
- MISR:
  - When the capture enable is high: m_next = {m[14:0], m[15]^m[13]^m[12]^m[10]} ^ {15'b0, resp_in}.
  - Otherwise m holds.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on start, load lfsr=SEED, set misr=0, pat_count=0, cap_cnt=0, go to RUN.
  - RUN: each cycle, apply the current pattern, advance the LFSR and increment pat_count. After the N_PATTERNS-th pattern, go to FLUSH.
  - FLUSH: lasts exactly LAT cycles with pat_out=0 and the LFSR held, then goes to DONE.
  - DONE: pass = (misr == golden_sig), computed on the transition into DONE and then held. done=1. On start, restart exactly as from IDLE, clearing done and pass in the same edge.
- Capture window:
  - MISR compaction is enabled in RUN when the RUN cycle index k ≥ LAT (k counts from 0), and in every FLUSH cycle.
  - Total captured responses = N_PATTERNS exactly; cap_cnt counts them.
  - If N_PATTERNS < LAT, capture still starts at RUN index LAT, which falls inside FLUSH. The count remains N_PATTERNS because FLUSH runs LAT cycles.
- start while busy=1 is ignored.
- Reset asserted mid-run aborts to IDLE with all reset values; no partial signature is retained.
- pat_count saturates at N_PATTERNS and holds through FLUSH and DONE until the next start.
- Latency: from the start edge to done=1 is N_PATTERNS+LAT+1 cycles. That is 1 cycle to enter RUN, N_PATTERNS cycles in RUN and LAT cycles in FLUSH, with done=1 in the cycle after the last FLUSH cycle.
- golden_sig must be stable from the start edge until done=1.

Test Plan:
- Reset check: hold I1477_rst=0 while toggling the clock and start. Required: pat_out=0, busy=0, done=0, pass=0, sig_out=16'h0000, pat_count=0. After release with no start, all outputs stay at their reset values.
- LFSR sequence: SEED=16'h0001, PAT_W=3, pulse start. Required pat_out over the first 4 RUN cycles: 3'b001, 3'b010, 3'b100, 3'b000. pat_count goes 1, 2, 3, 4.
- Stuck-at-0 response: resp_in=0, N_PATTERNS=8, LAT=4, golden_sig=16'h0000. Required: done=1 exactly 13 cycles after start, sig_out=16'h0000, pass=1, busy=0.
- Minimal run: N_PATTERNS=1, LAT=1, resp_in=1 constant, golden_sig=16'h0001. Required: sig_out=16'h0001 and pass=1 at done. Repeat with golden_sig=16'h0002; required pass=0.
- Control edge cases:
  - A start pulse during RUN is ignored; pat_count still ends at N_PATTERNS.
  - A start pulse in DONE clears done and pass on the next edge and reruns to an identical sig_out.
  - Reset pulsed mid-RUN returns to IDLE with sig_out=0.
- Golden-model compare: drive resp_in from a behavioural model of the target subcircuit with LAT=4, N_PATTERNS=1000. Required: sig_out equals the signature from the bench's reference MISR model and pass=1. Injecting one flipped response bit gives pass=0.
